// File: rtl/mem_arb_pkg.sv
// Shared types and default geometry for the cache-to-main-memory arbiter.
// Also imported by the ICache/DCache so all three agree on line width and latency.
package mem_arb_pkg;

   localparam int unsigned DEF_ADDR_W    = 32;
   localparam int unsigned DEF_LINE_BITS = 128;
   localparam int unsigned DEF_LATENCY   = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } arb_state_t;

   typedef enum logic {
      GNT_IC = 1'b0,
      GNT_DC = 1'b1
   } grant_t;

   typedef struct packed {
      logic                     we;
      logic [DEF_ADDR_W-1:0]    addr;
      logic [DEF_LINE_BITS-1:0] wdata;
   } mem_req_t;

   // Number of byte-offset bits inside one line.
   function automatic int unsigned line_offset_bits(input int unsigned line_bits);
      return $clog2(line_bits / 8);
   endfunction

endpackage

// File: rtl/mem_arb_select.sv
// Grant selection between ICache and DCache for mem_arbiter.
// Build with MEM_ARB_RR_EN for round-robin ties; otherwise DCache has fixed priority.
module mem_arb_select
   import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
   input  logic   clock,
   input  logic   reset,
   input  logic   take,
`endif
   input  logic   ic_req,
   input  logic   dc_req,
   output grant_t gnt
);

`ifdef MEM_ARB_RR_EN
   grant_t last_q;

   always_comb begin
      if (ic_req && dc_req) begin
         gnt = (last_q == GNT_IC) ? GNT_DC : GNT_IC;
      end else if (ic_req) begin
         gnt = GNT_IC;
      end else begin
         gnt = GNT_DC;
      end
   end

   // Starts at ICache so the first tie after reset goes to DCache.
   always_ff @(posedge clock) begin
      if (!reset) begin
         last_q <= GNT_IC;
      end else if (take) begin
         last_q <= gnt;
      end
   end
`else
   always_comb begin
      gnt = (ic_req && !dc_req) ? GNT_IC : GNT_DC;
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Serialises ICache refills and DCache refills/writebacks onto one line-wide memory port.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed DCache priority.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W    = DEF_ADDR_W,
   parameter int unsigned LINE_BITS = DEF_LINE_BITS,
   parameter int unsigned LATENCY   = DEF_LATENCY
) (
   input  logic                 clock,
   input  logic                 reset,

   input  logic                 ic_req,
   input  logic [ADDR_W-1:0]    ic_addr,
   output logic                 ic_done,
   output logic [LINE_BITS-1:0] ic_rdata,

   input  logic                 dc_req,
   input  logic                 dc_we,
   input  logic [ADDR_W-1:0]    dc_addr,
   input  logic [LINE_BITS-1:0] dc_wdata,
   output logic                 dc_done,
   output logic [LINE_BITS-1:0] dc_rdata,

   output logic                 mem_en,
   output logic                 mem_we,
   output logic [ADDR_W-1:0]    mem_addr,
   output logic [LINE_BITS-1:0] mem_wdata,
   input  logic [LINE_BITS-1:0] mem_rdata,

   output logic                 busy
);

   localparam int unsigned CNT_W = $clog2(LATENCY) + 1;
   localparam int unsigned OFF_W = line_offset_bits(LINE_BITS);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << OFF_W;

   arb_state_t           state_q, state_d;
   grant_t               gnt_q, gnt_d;
   grant_t               gnt_sel;
   logic                 we_q, we_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [LINE_BITS-1:0] wdata_q, wdata_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [LINE_BITS-1:0] line_q, line_d;

`ifdef MEM_ARB_RR_EN
   logic take;
   assign take = (state_q == IDLE) && (ic_req || dc_req);
`endif

   mem_arb_select u_select (
`ifdef MEM_ARB_RR_EN
      .clock  (clock),
      .reset  (reset),
      .take   (take),
`endif
      .ic_req (ic_req),
      .dc_req (dc_req),
      .gnt    (gnt_sel)
   );

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      cnt_d   = cnt_q;
      line_d  = line_q;
      unique case (state_q)
         IDLE: begin
            if (ic_req || dc_req) begin
               state_d = BUSY;
               gnt_d   = gnt_sel;
               cnt_d   = CNT_W'(LATENCY - 1);
               if (gnt_sel == GNT_DC) begin
                  we_d    = dc_we;
                  addr_d  = dc_addr & ALIGN_MASK;
                  wdata_d = dc_wdata;
               end else begin
                  we_d    = 1'b0;
                  addr_d  = ic_addr & ALIGN_MASK;
                  wdata_d = '0;
               end
            end
         end
         BUSY: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               state_d = DONE;
               if (!we_q) begin
                  line_d = mem_rdata;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= IDLE;
         gnt_q   <= GNT_DC;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         cnt_q   <= '0;
         line_q  <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         cnt_q   <= cnt_d;
         line_q  <= line_d;
      end
   end

   // All outputs decode registered state only; requests never reach them combinationally.
   assign busy      = (state_q != IDLE);
   assign mem_en    = (state_q == BUSY);
   assign mem_we    = mem_en && we_q && (cnt_q == '0);
   assign mem_addr  = mem_en ? addr_q : '0;
   assign mem_wdata = mem_en ? wdata_q : '0;

   assign ic_done  = (state_q == DONE) && (gnt_q == GNT_IC);
   assign dc_done  = (state_q == DONE) && (gnt_q == GNT_DC);
   // A writeback leaves the line register stale, so it is never returned.
   assign ic_rdata = (ic_done && !we_q) ? line_q : '0;
   assign dc_rdata = (dc_done && !we_q) ? line_q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level model of grant order,
// timing and memory contents, plus a LATENCY=1 instance.
module tb_mem_arbiter;
   localparam int unsigned LAT = 4;

   logic         clock;
   logic         reset;
   logic         ic_req, dc_req, dc_we;
   logic [31:0]  ic_addr, dc_addr;
   logic [127:0] dc_wdata;
   logic         ic_done, dc_done;
   logic [127:0] ic_rdata, dc_rdata;
   logic         mem_en, mem_we, busy;
   logic [31:0]  mem_addr;
   logic [127:0] mem_wdata, mem_rdata;

   logic         ic_req1, dc_req1, dc_we1;
   logic [31:0]  ic_addr1, dc_addr1;
   logic [127:0] dc_wdata1;
   logic         ic_done1, dc_done1;
   logic [127:0] ic_rdata1, dc_rdata1;
   logic         mem_en1, mem_we1, busy1;
   logic [31:0]  mem_addr1;
   logic [127:0] mem_wdata1, mem_rdata1;

   int total = 0;
   int bad   = 0;
   bit m_last_dc;
   logic [127:0] ref_mem [logic [31:0]];

   bit [127:0] env_mem [256];
   bit         env_vld [256];

   mem_arbiter #(.ADDR_W(32), .LINE_BITS(128), .LATENCY(LAT)) dut (
      .clock(clock), .reset(reset),
      .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done), .ic_rdata(ic_rdata),
      .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
      .dc_done(dc_done), .dc_rdata(dc_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   mem_arbiter #(.ADDR_W(32), .LINE_BITS(128), .LATENCY(1)) dut1 (
      .clock(clock), .reset(reset),
      .ic_req(ic_req1), .ic_addr(ic_addr1), .ic_done(ic_done1), .ic_rdata(ic_rdata1),
      .dc_req(dc_req1), .dc_we(dc_we1), .dc_addr(dc_addr1), .dc_wdata(dc_wdata1),
      .dc_done(dc_done1), .dc_rdata(dc_rdata1),
      .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
      .mem_rdata(mem_rdata1), .busy(busy1)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   function automatic logic [127:0] init_line(input logic [31:0] a);
      if (a == 32'h0000_1040) return {32{4'hA}};
      return {a ^ 32'hC3C3_0000, ~a, a + 32'h0101_0101, a ^ 32'h5555_AAAA};
   endfunction

   function automatic logic [7:0] env_idx(input logic [31:0] a);
      return {a[13:12], a[9:4]};
   endfunction

   function automatic logic [127:0] ref_read(input logic [31:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return init_line(a);
   endfunction

   function automatic logic [31:0] rnd_addr();
      return 32'(($urandom_range(0, 3) << 12) | ($urandom_range(0, 7) << 4) |
                 $urandom_range(0, 15));
   endfunction

   // Main memory seen by the LATENCY=4 instance.
   assign mem_rdata = env_vld[env_idx(mem_addr)] ? env_mem[env_idx(mem_addr)]
                                                 : init_line(mem_addr);
   always @(posedge clock) begin
      if (mem_we) begin
         env_mem[env_idx(mem_addr)] <= mem_wdata;
         env_vld[env_idx(mem_addr)] <= 1'b1;
      end
   end

   assign mem_rdata1 = {4{mem_addr1 ^ 32'h5A5A_0000}};

   task automatic test_reset();
      reset = 1'b0;
      ic_req = 0; dc_req = 0; dc_we = 0; ic_addr = '0; dc_addr = '0; dc_wdata = '0;
      ic_req1 = 0; dc_req1 = 0; dc_we1 = 0; ic_addr1 = '0; dc_addr1 = '0; dc_wdata1 = '0;
      repeat (3) @(posedge clock);
      #1;
      ic_req = 1; dc_req = 1; dc_we = 1; dc_wdata = {4{32'hFFFF_FFFF}};
      @(negedge clock);
      total++;
      if ({busy, mem_en, mem_we, ic_done, dc_done} !== 5'b0) begin
         bad++; $display("FAIL reset_ctrl got=%b exp=00000", {busy, mem_en, mem_we, ic_done, dc_done});
      end
      total++;
      if (mem_addr !== 32'h0) begin
         bad++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr);
      end
      total++;
      if (mem_wdata !== 128'h0) begin
         bad++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata);
      end
      total++;
      if ((ic_rdata | dc_rdata) !== 128'h0) begin
         bad++; $display("FAIL reset_rdata got=%h/%h exp=0", ic_rdata, dc_rdata);
      end
      total++;
      if ({busy1, mem_en1, ic_done1, dc_done1} !== 4'b0) begin
         bad++; $display("FAIL reset_dut1 got=%b exp=0000", {busy1, mem_en1, ic_done1, dc_done1});
      end
      @(posedge clock); #1;
      ic_req = 0; dc_req = 0; dc_we = 0; dc_wdata = '0;
      reset = 1'b1;
      @(negedge clock);
      total++;
      if (busy !== 1'b0) begin
         bad++; $display("FAIL reset_release_busy got=%b exp=0", busy);
      end
      @(posedge clock); #1;
      m_last_dc = 1'b0;
   endtask

   // Runs up to one ICache and one DCache request starting at the given cycles (-1 = none)
   // and compares every output in every cycle against the transaction-level model.
   task automatic run_pair(input string tag, input int ic_at, input logic [31:0] ia,
                           input int dc_at, input bit dwe, input logic [31:0] da,
                           input logic [127:0] dwd);
      int s [2];
      bit is_ic [2];
      bit twe [2];
      logic [31:0] tad [2];
      logic [127:0] trd [2];
      int ntx = 0;
      int t_free = 0;
      bit ic_p = (ic_at >= 0);
      bit dc_p = (dc_at >= 0);
      int ic_dn = -10;
      int dc_dn = -10;
      int end_c = 2;
      for (int k = 0; k < 2; k++) begin
         int t;
         bit ic_r, dc_r, pick_ic;
         if (ic_p || dc_p) begin
            t = ic_p ? ic_at : dc_at;
            if (dc_p && dc_at < t) t = dc_at;
            if (t < t_free) t = t_free;
            ic_r = ic_p && (ic_at <= t);
            dc_r = dc_p && (dc_at <= t);
            if (ic_r && dc_r) begin
`ifdef MEM_ARB_RR_EN
               pick_ic = m_last_dc;
`else
               pick_ic = 1'b0;
`endif
            end else begin
               pick_ic = ic_r;
            end
            s[ntx]     = t;
            is_ic[ntx] = pick_ic;
            twe[ntx]   = pick_ic ? 1'b0 : dwe;
            tad[ntx]   = (pick_ic ? ia : da) & ~32'hF;
            if (twe[ntx]) begin
               ref_mem[tad[ntx]] = dwd;
               trd[ntx] = '0;
            end else begin
               trd[ntx] = ref_read(tad[ntx]);
            end
            if (pick_ic) begin
               ic_p = 1'b0; ic_dn = t + LAT + 1;
            end else begin
               dc_p = 1'b0; dc_dn = t + LAT + 1;
            end
            m_last_dc = !pick_ic;
            t_free = t + LAT + 2;
            end_c = t + LAT + 3;
            ntx++;
         end
      end

      ic_addr = ia; dc_we = dwe; dc_addr = da; dc_wdata = dwd;
      for (int c = 0; c <= end_c; c++) begin
         bit e_en, e_we, e_busy, e_icd, e_dcd, e_wchk;
         logic [31:0] e_addr;
         logic [127:0] e_icr, e_dcr;
         if (c == ic_at) ic_req = 1'b1;
         if (c == dc_at) dc_req = 1'b1;
         if (c == ic_dn + 1) ic_req = 1'b0;
         if (c == dc_dn + 1) dc_req = 1'b0;
         @(negedge clock);
         e_en = 0; e_we = 0; e_busy = 0; e_icd = 0; e_dcd = 0; e_wchk = 0;
         e_addr = '0; e_icr = '0; e_dcr = '0;
         for (int k = 0; k < ntx; k++) begin
            if (c >= s[k] + 1 && c <= s[k] + LAT) begin
               e_en = 1; e_addr = tad[k]; e_wchk = twe[k];
            end
            if (c == s[k] + LAT && twe[k]) e_we = 1;
            if (c >= s[k] + 1 && c <= s[k] + LAT + 1) e_busy = 1;
            if (c == s[k] + LAT + 1) begin
               if (is_ic[k]) begin e_icd = 1; e_icr = trd[k]; end
               else begin e_dcd = 1; e_dcr = trd[k]; end
            end
         end
         total++;
         if (busy !== e_busy) begin
            bad++; if (bad < 50) $display("FAIL %s busy cyc=%0d got=%b exp=%b", tag, c, busy, e_busy);
         end
         total++;
         if (mem_en !== e_en) begin
            bad++; if (bad < 50) $display("FAIL %s mem_en cyc=%0d got=%b exp=%b", tag, c, mem_en, e_en);
         end
         total++;
         if (mem_we !== e_we) begin
            bad++; if (bad < 50) $display("FAIL %s mem_we cyc=%0d got=%b exp=%b", tag, c, mem_we, e_we);
         end
         total++;
         if (ic_done !== e_icd) begin
            bad++; if (bad < 50) $display("FAIL %s ic_done cyc=%0d got=%b exp=%b", tag, c, ic_done, e_icd);
         end
         total++;
         if (dc_done !== e_dcd) begin
            bad++; if (bad < 50) $display("FAIL %s dc_done cyc=%0d got=%b exp=%b", tag, c, dc_done, e_dcd);
         end
         total++;
         if (ic_rdata !== e_icr) begin
            bad++; if (bad < 50) $display("FAIL %s ic_rdata cyc=%0d got=%h exp=%h", tag, c, ic_rdata, e_icr);
         end
         total++;
         if (dc_rdata !== e_dcr) begin
            bad++; if (bad < 50) $display("FAIL %s dc_rdata cyc=%0d got=%h exp=%h", tag, c, dc_rdata, e_dcr);
         end
         if (e_en) begin
            total++;
            if (mem_addr !== e_addr) begin
               bad++; if (bad < 50) $display("FAIL %s mem_addr cyc=%0d got=%h exp=%h", tag, c, mem_addr, e_addr);
            end
         end
         if (e_en && e_wchk) begin
            total++;
            if (mem_wdata !== dwd) begin
               bad++; if (bad < 50) $display("FAIL %s mem_wdata cyc=%0d got=%h exp=%h", tag, c, mem_wdata, dwd);
            end
         end
         @(posedge clock); #1;
      end
      ic_req = 1'b0; dc_req = 1'b0;
   endtask

   task automatic test_icache_read();
      run_pair("ic_read", 0, 32'h0000_104C, -1, 1'b0, 32'h0, '0);
   endtask

   task automatic test_dc_writeback();
      run_pair("dc_wb", -1, 32'h0, 0, 1'b1, 32'h0000_2000, {8{16'h1234}});
      run_pair("dc_wb_readback", -1, 32'h0, 0, 1'b0, 32'h0000_2000, '0);
   endtask

   task automatic test_tie();
      run_pair("tie1", 0, 32'h0000_1010, 0, 1'b0, 32'h0000_3020, '0);
      run_pair("tie_dc_only", -1, 32'h0, 0, 1'b1, 32'h0000_3030, {4{32'hC0FF_EE00}});
      run_pair("tie2", 0, 32'h0000_1020, 0, 1'b0, 32'h0000_2010, '0);
   endtask

   task automatic test_late_ic();
      run_pair("late_ic", 2, 32'h0000_1230, 0, 1'b0, 32'h0000_2040, '0);
   endtask

   task automatic test_reset_mid();
      int we_seen = 0;
      int done_seen = 0;
      dc_req = 1'b1; dc_we = 1'b1; dc_addr = 32'h0000_3010;
      dc_wdata = {$urandom, $urandom, $urandom, $urandom};
      for (int c = 0; c < 10; c++) begin
         if (c == 2) reset = 1'b0;
         if (c == 3) begin reset = 1'b1; dc_req = 1'b0; end
         @(negedge clock);
         if (mem_we) we_seen++;
         if (ic_done || dc_done) done_seen++;
         if (c == 3) begin
            total++;
            if ({busy, mem_en, mem_we, ic_done, dc_done} !== 5'b0) begin
               bad++; $display("FAIL rst_mid_ctrl got=%b exp=00000", {busy, mem_en, mem_we, ic_done, dc_done});
            end
            total++;
            if ({mem_addr, mem_wdata, ic_rdata, dc_rdata} !== '0) begin
               bad++; $display("FAIL rst_mid_data got=%h/%h exp=0", mem_addr, mem_wdata);
            end
         end
         @(posedge clock); #1;
      end
      total++;
      if (we_seen !== 0) begin
         bad++; $display("FAIL rst_mid_we_pulses got=%0d exp=0", we_seen);
      end
      total++;
      if (done_seen !== 0) begin
         bad++; $display("FAIL rst_mid_done got=%0d exp=0", done_seen);
      end
      m_last_dc = 1'b0;
      run_pair("rst_mid_readback", -1, 32'h0, 0, 1'b0, 32'h0000_3010, '0);
   endtask

   task automatic test_latency_one();
      logic [127:0] exp_line;
      exp_line = {4{32'h0000_0230 ^ 32'h5A5A_0000}};
      ic_addr1 = 32'h0000_0238; ic_req1 = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         @(posedge clock); #1;
         if (c == 3) ic_req1 = 1'b0;
         @(negedge clock);
         total++;
         if (mem_en1 !== (c == 1)) begin
            bad++; $display("FAIL lat1_mem_en cyc=%0d got=%b exp=%b", c, mem_en1, (c == 1));
         end
         total++;
         if (busy1 !== (c == 1 || c == 2)) begin
            bad++; $display("FAIL lat1_busy cyc=%0d got=%b exp=%b", c, busy1, (c == 1 || c == 2));
         end
         total++;
         if (ic_done1 !== (c == 2) || dc_done1 !== 1'b0) begin
            bad++; $display("FAIL lat1_done cyc=%0d got=%b%b exp=%b0", c, ic_done1, dc_done1, (c == 2));
         end
         total++;
         if (ic_rdata1 !== ((c == 2) ? exp_line : 128'h0)) begin
            bad++; $display("FAIL lat1_rdata cyc=%0d got=%h exp=%h", c, ic_rdata1,
                            (c == 2) ? exp_line : 128'h0);
         end
         if (c == 1) begin
            total++;
            if (mem_addr1 !== 32'h0000_0230) begin
               bad++; $display("FAIL lat1_addr got=%h exp=00000230", mem_addr1);
            end
         end
      end
      @(posedge clock); #1;
   endtask

   task automatic test_random();
      for (int n = 0; n < 20; n++) begin
         int ia_t, da_t;
         ia_t = int'($urandom_range(0, 7)) - 1;
         da_t = int'($urandom_range(0, 7)) - 1;
         run_pair("random", ia_t, rnd_addr(), da_t, 1'($urandom_range(0, 1)), rnd_addr(),
                  {$urandom, $urandom, $urandom, $urandom});
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_tie();
      test_icache_read();
      test_dc_writeback();
      test_late_ic();
      test_reset_mid();
      test_latency_one();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
